dma_mem_responder: RTL and testbench

Memory-side responder for the packet DMA's memory write and read ports. It serves the DMA's write and read ports from an on-chip byte-writable packet RAM. Reads pass through a 2-entry return buffer, so read data obeys the DMA's valid/ready return handshake without a combinational path from `mem_rd_data_ready`. External arbiter blocks, per-port burst counters and an out-of-range error flag support integration next to the core-side memory arbiter.

---
 rtl/dma_mem_responder.sv | 131 +++++++++++++
 tb/tb_dma_mem_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_mem_responder.sv
// Memory-side responder for the packet DMA: byte-writable packet RAM behind the write
// and read ports, with a 2-entry read return buffer, arbiter holds, burst counters and an address error flag.
module dma_mem_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int MASK_BITS  = $clog2(STRB_WIDTH),
  parameter int MEM_WORDS  = 2**(ADDR_WIDTH-MASK_BITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_wr_en,
  input  logic [STRB_WIDTH-1:0] i_mem_wr_strb,
  input  logic [ADDR_WIDTH-1:0] i_mem_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_wr_data,
  input  logic                  i_mem_wr_last,
  output logic                  o_mem_wr_ready,
  input  logic                  i_mem_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_mem_rd_addr,
  input  logic                  i_mem_rd_last,
  output logic                  o_mem_rd_ready,
  output logic [DATA_WIDTH-1:0] o_mem_rd_data,
  output logic                  o_mem_rd_data_v,
  input  logic                  i_mem_rd_data_ready,
  input  logic                  i_wr_block,
  input  logic                  i_rd_block,
  output logic [15:0]           o_wr_pkt_count,
  output logic [15:0]           o_rd_burst_count,
  output logic                  o_addr_err
);

  localparam int IDX_WIDTH = ADDR_WIDTH - MASK_BITS;
  localparam int RAM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  r_head;
  logic [1:0]            r_count;
  logic [15:0]           r_wr_pkt_count;
  logic [15:0]           r_rd_burst_count;
  logic                  r_addr_err;

  logic [IDX_WIDTH-1:0]  w_wr_idx;
  logic [IDX_WIDTH-1:0]  w_rd_idx;
  logic [RAM_AW-1:0]     w_wr_ram_addr;
  logic [RAM_AW-1:0]     w_rd_ram_addr;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic                  w_pop;
  logic                  w_tail;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_unused_addr_lsbs;

  assign w_wr_idx      = i_mem_wr_addr[ADDR_WIDTH-1:MASK_BITS];
  assign w_rd_idx      = i_mem_rd_addr[ADDR_WIDTH-1:MASK_BITS];
  assign w_wr_ram_addr = w_wr_idx[RAM_AW-1:0];
  assign w_rd_ram_addr = w_rd_idx[RAM_AW-1:0];
  assign w_wr_in_range = 32'(w_wr_idx) < 32'(MEM_WORDS);
  assign w_rd_in_range = 32'(w_rd_idx) < 32'(MEM_WORDS);
  assign w_unused_addr_lsbs = ^{i_mem_wr_addr[MASK_BITS-1:0], i_mem_rd_addr[MASK_BITS-1:0]};

  // Ready depends only on the hold inputs and registered fill level, never on a same-cycle pop.
  assign o_mem_wr_ready = !i_wr_block;
  assign o_mem_rd_ready = !i_rd_block && (r_count < 2'd2);
  assign w_wr_accept    = i_mem_wr_en && o_mem_wr_ready;
  assign w_rd_accept    = i_mem_rd_en && o_mem_rd_ready;
  assign w_pop          = (r_count != 2'd0) && i_mem_rd_data_ready;
  assign w_tail         = r_head ^ r_count[0];

  // Asynchronous RAM read sampled into the buffer at the edge gives read-first behaviour.
  assign w_rd_word = w_rd_in_range ? r_mem[w_rd_ram_addr] : '0;

  always_ff @(posedge clk) begin
    if (!rst && w_wr_accept && w_wr_in_range) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (i_mem_wr_strb[i]) begin
          r_mem[w_wr_ram_addr][i*8 +: 8] <= i_mem_wr_data[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head    <= 1'b0;
      r_count   <= 2'd0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
    end else begin
      if (w_rd_accept) begin
        r_fifo[w_tail] <= w_rd_word;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      if (w_rd_accept && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (!w_rd_accept && w_pop) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  assign o_mem_rd_data_v = (r_count != 2'd0);
  assign o_mem_rd_data   = (r_count != 2'd0) ? r_fifo[r_head] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_pkt_count   <= 16'd0;
      r_rd_burst_count <= 16'd0;
      r_addr_err       <= 1'b0;
    end else begin
      if (w_wr_accept && i_mem_wr_last) begin
        r_wr_pkt_count <= r_wr_pkt_count + 16'd1;
      end
      if (w_rd_accept && i_mem_rd_last) begin
        r_rd_burst_count <= r_rd_burst_count + 16'd1;
      end
      if ((w_wr_accept && !w_wr_in_range) || (w_rd_accept && !w_rd_in_range)) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  assign o_wr_pkt_count   = r_wr_pkt_count;
  assign o_rd_burst_count = r_rd_burst_count;
  assign o_addr_err       = r_addr_err;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Bench for dma_mem_responder: directed vector table, hand-written multi-cycle sequences
// and random traffic, all checked against a queue-based reference model of the memory port.
module tb_dma_mem_responder;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam int SW = DW/8;
  localparam int MW = 1024;
  localparam logic [DW-1:0] ALL = '1;

  logic clk = 1'b0;
  logic rst;
  logic wrEn, wrLast, rdEn, rdLast, dataReady, wrBlock, rdBlock;
  logic [SW-1:0] wrStrb;
  logic [AW-1:0] wrAddr, rdAddr;
  logic [DW-1:0] wrData;
  logic wrReady, rdReady, rdDataV, addrErr;
  logic [DW-1:0] rdData;
  logic [15:0] wrPktCount, rdBurstCount;

  always #5 clk = ~clk;

  dma_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst),
    .i_mem_wr_en(wrEn), .i_mem_wr_strb(wrStrb), .i_mem_wr_addr(wrAddr),
    .i_mem_wr_data(wrData), .i_mem_wr_last(wrLast), .o_mem_wr_ready(wrReady),
    .i_mem_rd_en(rdEn), .i_mem_rd_addr(rdAddr), .i_mem_rd_last(rdLast),
    .o_mem_rd_ready(rdReady), .o_mem_rd_data(rdData), .o_mem_rd_data_v(rdDataV),
    .i_mem_rd_data_ready(dataReady), .i_wr_block(wrBlock), .i_rd_block(rdBlock),
    .o_wr_pkt_count(wrPktCount), .o_rd_burst_count(rdBurstCount), .o_addr_err(addrErr)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
  } retT;

  typedef struct {
    logic          wrEn;
    logic [SW-1:0] wrStrb;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic          wrLast;
    logic          rdEn;
    logic [AW-1:0] rdAddr;
    logic          rdLast;
    logic          expV;
    logic [DW-1:0] expData;
    logic [15:0]   expWrCnt;
    logic          expErr;
  } vecT;

  // Reference model: word array with per-byte "known" masks and an in-order return queue.
  logic [DW-1:0] mdlMem [MW];
  logic [DW-1:0] mdlKnown [MW];
  retT           mdlQ[$];
  logic [15:0]   mdlWrCnt, mdlRdCnt;
  logic          mdlErr;

  int vectors = 0;
  int miscompares = 0;

  logic smpWrRdy, smpRdRdy, smpV, smpErr;
  logic [DW-1:0] smpData;
  logic [15:0] smpWrCnt, smpRdCnt;

  vecT vecs[$];

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp, input logic [DW-1:0] mask);
    vectors++;
    if ((act & mask) !== (exp & mask)) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act & mask, exp & mask, $time);
    end
  endtask

  // One clock cycle: sample outputs, compare with the model, advance the model, clock the DUT.
  task automatic applyStimulus();
    retT r;
    int wIdx, rIdx;
    logic expWrRdy, expRdRdy, wrAcc, rdAcc, pop;
    #1;
    smpWrRdy = wrReady;
    smpRdRdy = rdReady;
    smpV     = rdDataV;
    smpData  = rdData;
    smpWrCnt = wrPktCount;
    smpRdCnt = rdBurstCount;
    smpErr   = addrErr;
    expWrRdy = !wrBlock;
    expRdRdy = !rdBlock && (mdlQ.size() < 2);
    if (!rst) begin
      checkOutput("model wr_ready", 64'(wrReady), 64'(expWrRdy), ALL);
      checkOutput("model rd_ready", 64'(rdReady), 64'(expRdRdy), ALL);
      checkOutput("model rd_data_v", 64'(rdDataV), 64'(mdlQ.size() != 0), ALL);
      if (mdlQ.size() != 0) checkOutput("model rd_data", rdData, mdlQ[0].data, mdlQ[0].mask);
      else checkOutput("model rd_data idle", rdData, '0, ALL);
      checkOutput("model wr_pkt_count", 64'(wrPktCount), 64'(mdlWrCnt), ALL);
      checkOutput("model rd_burst_count", 64'(rdBurstCount), 64'(mdlRdCnt), ALL);
      checkOutput("model addr_err", 64'(addrErr), 64'(mdlErr), ALL);
    end
    if (rst) begin
      mdlQ.delete();
      mdlWrCnt = '0;
      mdlRdCnt = '0;
      mdlErr   = 1'b0;
    end else begin
      wrAcc = wrEn && expWrRdy;
      rdAcc = rdEn && expRdRdy;
      pop   = (mdlQ.size() != 0) && dataReady;
      r.data = '0;
      r.mask = ALL;
      if (rdAcc) begin
        rIdx = int'(rdAddr) / SW;
        if (rIdx < MW) begin
          r.data = mdlMem[rIdx];
          r.mask = mdlKnown[rIdx];
        end else begin
          mdlErr = 1'b1;
        end
        if (rdLast) mdlRdCnt = mdlRdCnt + 16'd1;
      end
      if (wrAcc) begin
        wIdx = int'(wrAddr) / SW;
        if (wIdx < MW) begin
          for (int b = 0; b < SW; b++) begin
            if (wrStrb[b]) begin
              mdlMem[wIdx][8*b +: 8]   = wrData[8*b +: 8];
              mdlKnown[wIdx][8*b +: 8] = 8'hFF;
            end
          end
        end else begin
          mdlErr = 1'b1;
        end
        if (wrLast) mdlWrCnt = mdlWrCnt + 16'd1;
      end
      if (pop) void'(mdlQ.pop_front());
      if (rdAcc) mdlQ.push_back(r);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    wrEn = 0; wrStrb = '0; wrAddr = '0; wrData = '0; wrLast = 0;
    rdEn = 0; rdAddr = '0; rdLast = 0;
  endtask

  function automatic vecT mkVec(logic we, logic [SW-1:0] ws, logic [AW-1:0] wa, logic [DW-1:0] wd,
                                logic wl, logic re, logic [AW-1:0] ra, logic rl, logic ev,
                                logic [DW-1:0] ed, logic [15:0] ewc, logic ee);
    vecT v;
    v.wrEn = we; v.wrStrb = ws; v.wrAddr = wa; v.wrData = wd; v.wrLast = wl;
    v.rdEn = re; v.rdAddr = ra; v.rdLast = rl;
    v.expV = ev; v.expData = ed; v.expWrCnt = ewc; v.expErr = ee;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int next, drained, startCnt;
    logic [DW-1:0] got[$];

    for (int i = 0; i < MW; i++) mdlKnown[i] = '0;
    mdlWrCnt = '0; mdlRdCnt = '0; mdlErr = 1'b0;
    rst = 1; dataReady = 0; wrBlock = 0; rdBlock = 0;
    idleInputs();

    // Directed table: write/readback, partial strobe, read-first collision, out-of-range, zero strobe.
    vecs.push_back(mkVec(1, 8'hFF, 16'h0108, 64'h5555_6666_7777_8888, 0, 0, 16'h0000, 0, 0, 64'h0, 16'd0, 0));
    vecs.push_back(mkVec(1, 8'hFF, 16'h0100, 64'h1111_2222_3333_4444, 0, 0, 16'h0000, 0, 0, 64'h0, 16'd0, 0));
    vecs.push_back(mkVec(1, 8'h0F, 16'h0108, 64'hAAAA_AAAA_AAAA_AAAA, 1, 0, 16'h0000, 0, 0, 64'h0, 16'd0, 0));
    vecs.push_back(mkVec(0, 8'h00, 16'h0000, 64'h0, 0, 1, 16'h0100, 0, 0, 64'h0, 16'd1, 0));
    vecs.push_back(mkVec(0, 8'h00, 16'h0000, 64'h0, 0, 1, 16'h0108, 1, 1, 64'h1111_2222_3333_4444, 16'd1, 0));
    vecs.push_back(mkVec(0, 8'h00, 16'h0000, 64'h0, 0, 0, 16'h0000, 0, 1, 64'h5555_6666_AAAA_AAAA, 16'd1, 0));
    vecs.push_back(mkVec(0, 8'h00, 16'h0000, 64'h0, 0, 0, 16'h0000, 0, 0, 64'h0, 16'd1, 0));
    vecs.push_back(mkVec(1, 8'hFF, 16'h0028, 64'hBEEF, 0, 0, 16'h0000, 0, 0, 64'h0, 16'd1, 0));
    vecs.push_back(mkVec(1, 8'hFF, 16'h0028, 64'hDEAD, 0, 1, 16'h0028, 0, 0, 64'h0, 16'd1, 0));
    vecs.push_back(mkVec(0, 8'h00, 16'h0000, 64'h0, 0, 1, 16'h0028, 0, 1, 64'hBEEF, 16'd1, 0));
    vecs.push_back(mkVec(0, 8'h00, 16'h0000, 64'h0, 0, 0, 16'h0000, 0, 1, 64'hDEAD, 16'd1, 0));
    vecs.push_back(mkVec(0, 8'h00, 16'h0000, 64'h0, 0, 0, 16'h0000, 0, 0, 64'h0, 16'd1, 0));
    vecs.push_back(mkVec(1, 8'hFF, 16'h2000, 64'h1234, 0, 0, 16'h0000, 0, 0, 64'h0, 16'd1, 0));
    vecs.push_back(mkVec(0, 8'h00, 16'h0000, 64'h0, 0, 1, 16'h2000, 0, 0, 64'h0, 16'd1, 1));
    vecs.push_back(mkVec(0, 8'h00, 16'h0000, 64'h0, 0, 0, 16'h0000, 0, 1, 64'h0, 16'd1, 1));
    vecs.push_back(mkVec(0, 8'h00, 16'h0000, 64'h0, 0, 0, 16'h0000, 0, 0, 64'h0, 16'd1, 1));
    vecs.push_back(mkVec(1, 8'h00, 16'h0100, ALL, 1, 0, 16'h0000, 0, 0, 64'h0, 16'd1, 1));
    vecs.push_back(mkVec(0, 8'h00, 16'h0000, 64'h0, 0, 1, 16'h0100, 0, 0, 64'h0, 16'd2, 1));
    vecs.push_back(mkVec(0, 8'h00, 16'h0000, 64'h0, 0, 0, 16'h0000, 0, 1, 64'h1111_2222_3333_4444, 16'd2, 1));
    vecs.push_back(mkVec(0, 8'h00, 16'h0000, 64'h0, 0, 0, 16'h0000, 0, 0, 64'h0, 16'd2, 1));

    @(negedge clk);
    applyStimulus();
    applyStimulus();

    // Reset state, then hold inputs forcing both readies low.
    rst = 0;
    applyStimulus();
    checkOutput("reset wr_ready", 64'(smpWrRdy), 64'(1), ALL);
    checkOutput("reset rd_ready", 64'(smpRdRdy), 64'(1), ALL);
    checkOutput("reset rd_data_v", 64'(smpV), 64'(0), ALL);
    checkOutput("reset rd_data", smpData, 64'h0, ALL);
    checkOutput("reset wr_pkt_count", 64'(smpWrCnt), 64'(0), ALL);
    checkOutput("reset rd_burst_count", 64'(smpRdCnt), 64'(0), ALL);
    checkOutput("reset addr_err", 64'(smpErr), 64'(0), ALL);
    wrBlock = 1; rdBlock = 1;
    applyStimulus();
    checkOutput("blocked wr_ready", 64'(smpWrRdy), 64'(0), ALL);
    checkOutput("blocked rd_ready", 64'(smpRdRdy), 64'(0), ALL);
    wrBlock = 0; rdBlock = 0;

    dataReady = 1;
    foreach (vecs[i]) begin
      wrEn = vecs[i].wrEn; wrStrb = vecs[i].wrStrb; wrAddr = vecs[i].wrAddr;
      wrData = vecs[i].wrData; wrLast = vecs[i].wrLast;
      rdEn = vecs[i].rdEn; rdAddr = vecs[i].rdAddr; rdLast = vecs[i].rdLast;
      applyStimulus();
      checkOutput($sformatf("vec%0d rd_data_v", i), 64'(smpV), 64'(vecs[i].expV), ALL);
      checkOutput($sformatf("vec%0d rd_data", i), smpData, vecs[i].expData, ALL);
      checkOutput($sformatf("vec%0d wr_pkt_count", i), 64'(smpWrCnt), 64'(vecs[i].expWrCnt), ALL);
      checkOutput($sformatf("vec%0d addr_err", i), 64'(smpErr), 64'(vecs[i].expErr), ALL);
    end
    idleInputs();

    // Fill words 0x80..0x87 for the burst tests.
    for (int k = 0; k < 8; k++) begin
      wrEn = 1; wrStrb = 8'hFF; wrAddr = 16'(16'h0400 + 8*k); wrData = 64'hC0DE_0000_0000_0000 + 64'(k);
      wrLast = (k == 7);
      applyStimulus();
    end
    idleInputs();

    // 8-word burst against a stalled consumer, then release.
    startCnt = int'(mdlRdCnt);
    dataReady = 0;
    next = 0;
    for (int c = 0; c < 6; c++) begin
      rdEn = (next < 8); rdAddr = 16'(16'h0400 + 8*next); rdLast = (next == 7);
      applyStimulus();
      if (rdEn && smpRdRdy) next++;
    end
    checkOutput("burst stalled accepts", 64'(next), 64'(2), ALL);
    checkOutput("burst stalled rd_ready", 64'(smpRdRdy), 64'(0), ALL);
    dataReady = 1;
    for (int c = 0; c < 40 && got.size() < 8; c++) begin
      rdEn = (next < 8); rdAddr = 16'(16'h0400 + 8*next); rdLast = (next == 7);
      applyStimulus();
      if (rdEn && smpRdRdy) next++;
      if (smpV) got.push_back(smpData);
    end
    idleInputs();
    checkOutput("burst word count", 64'(got.size()), 64'(8), ALL);
    foreach (got[k]) checkOutput($sformatf("burst word%0d", k), got[k], 64'hC0DE_0000_0000_0000 + 64'(k), ALL);
    applyStimulus();
    checkOutput("burst rd_burst_count", 64'(smpRdCnt), 64'(startCnt + 1), ALL);

    // Buffered data drains while rd_block holds off new reads.
    dataReady = 0;
    for (int k = 0; k < 2; k++) begin
      rdEn = 1; rdAddr = 16'(16'h0400 + 8*k);
      applyStimulus();
    end
    rdBlock = 1; dataReady = 1; drained = 0;
    for (int c = 0; c < 3; c++) begin
      rdEn = 1; rdAddr = 16'h0410;
      applyStimulus();
      checkOutput($sformatf("rd_block rd_ready c%0d", c), 64'(smpRdRdy), 64'(0), ALL);
      if (smpV) begin
        checkOutput("rd_block drain data", smpData, 64'hC0DE_0000_0000_0000 + 64'(drained), ALL);
        drained++;
      end
    end
    checkOutput("rd_block drained words", 64'(drained), 64'(2), ALL);
    rdBlock = 0; idleInputs();

    // Blocked writes must not touch the RAM.
    wrBlock = 1;
    for (int c = 0; c < 3; c++) begin
      wrEn = 1; wrStrb = 8'hFF; wrAddr = 16'h0400; wrData = ALL; wrLast = 1;
      applyStimulus();
      checkOutput($sformatf("wr_block wr_ready c%0d", c), 64'(smpWrRdy), 64'(0), ALL);
    end
    wrBlock = 0; idleInputs();
    rdEn = 1; rdAddr = 16'h0400;
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkOutput("wr_block ram unchanged", smpData, 64'hC0DE_0000_0000_0000, ALL);

    // Reset with two words buffered; a write in the reset cycle is not performed.
    dataReady = 0;
    for (int k = 2; k < 4; k++) begin
      rdEn = 1; rdAddr = 16'(16'h0400 + 8*k);
      applyStimulus();
    end
    idleInputs();
    rst = 1; wrEn = 1; wrStrb = 8'hFF; wrAddr = 16'h0420; wrData = 64'h0;
    applyStimulus();
    rst = 0; idleInputs();
    applyStimulus();
    checkOutput("post-reset rd_data_v", 64'(smpV), 64'(0), ALL);
    checkOutput("post-reset rd_ready", 64'(smpRdRdy), 64'(1), ALL);
    checkOutput("post-reset wr_pkt_count", 64'(smpWrCnt), 64'(0), ALL);
    checkOutput("post-reset rd_burst_count", 64'(smpRdCnt), 64'(0), ALL);
    checkOutput("post-reset addr_err", 64'(smpErr), 64'(0), ALL);
    dataReady = 1; rdEn = 1; rdAddr = 16'h0420;
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkOutput("post-reset ram kept", smpData, 64'hC0DE_0000_0000_0004, ALL);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      wrEn = $urandom_range(0, 1);
      wrStrb = SW'($urandom);
      wrData = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) begin
        wrAddr = 16'((MW + $urandom_range(0, 3)) * SW + $urandom_range(0, 7));
        wrLast = 0;
      end else begin
        wrAddr = 16'($urandom_range(0, 15) * SW + $urandom_range(0, 7));
        wrLast = $urandom_range(0, 1);
      end
      rdEn = $urandom_range(0, 1);
      rdLast = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) rdAddr = 16'((MW + $urandom_range(0, 3)) * SW);
      else rdAddr = 16'($urandom_range(0, 15) * SW + $urandom_range(0, 7));
      dataReady = ($urandom_range(0, 9) < 7);
      wrBlock = ($urandom_range(0, 9) < 2);
      rdBlock = ($urandom_range(0, 9) < 2);
      applyStimulus();
    end
    idleInputs(); wrBlock = 0; rdBlock = 0; dataReady = 1;
    applyStimulus();
    applyStimulus();
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
